ucs_flip_scheduler: RTL
=======================

Name: ucs_flip_scheduler

Overview:
- Top-level sequencer for the unsat clause selector datapath.
- Loads the initial unsat clause list into the unsat buffer (setup phase).
- Then repeatedly issues selection requests, captures each selected clause and hands it to the variable-flip stage over a valid/ready handshake.
- Waits for flip completion, ends on SAT (empty buffer), flip budget exhaustion or error.

Parameters:
- BUFFER_DEPTH, 2048, unsat buffer depth, power of 2; BUF_ADDR_WIDTH = clog2(BUFFER_DEPTH).
- NSAT, 3, literals per clause.
- LITERAL_ADDRESS_WIDTH, 12, bits per literal; CLAUSE_WIDTH = NSAT*LITERAL_ADDRESS_WIDTH.
- FLIP_COUNT_WIDTH, 32, width of flip counter and budget.
- SEL_LATENCY, 4, cycles from request_o to selected_i valid.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- start_i  in  1  pulse; begin load (IDLE only)
- load_valid_i  in  1  host clause valid
- load_ready_o  out  1  accept host clause
- load_data_i  in  CLAUSE_WIDTH  host clause
- load_last_i  in  1  marks final clause of load
- setup_o  out  1  selector setup mode
- ucb_setup_wr_en_o  out  1  setup write strobe
- ucb_setup_addr_o  out  BUF_ADDR_WIDTH  setup write address
- ucb_setup_data_o  out  CLAUSE_WIDTH  setup write data
- request_o  out  1  one-cycle selection request
- write_disable_o  out  1  freeze unsat buffer
- clear_debug_div_by_zero_o  out  1  clear sticky flag
- debug_div_by_zero_i  in  1  selector divide-by-zero flag
- buffer_count_i  in  BUF_ADDR_WIDTH  unsat clause count
- ucb_overflow_i  in  1  buffer overflow
- selected_i  in  CLAUSE_WIDTH  selected clause
- clause_valid_o  out  1  selected clause valid
- clause_ready_i  in  1  flip stage accepts clause
- clause_o  out  CLAUSE_WIDTH  registered selected clause
- flip_done_i  in  1  pulse; flip applied and FIFO updates finished
- max_flips_i  in  FLIP_COUNT_WIDTH  flip budget, 0 = unlimited
- flip_count_o  out  FLIP_COUNT_WIDTH  flips completed
- sat_o, timeout_o, error_o  out  1 each  sticky terminal flags
- busy_o  out  1  not IDLE and not terminal

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0, except write_disable_o=1; clause_o=0; internal setup address=0.
- States: IDLE, LOAD, SETTLE, REQ, WAIT, PRESENT, FLIP, SAT, TIMEOUT, ERROR.
- IDLE:
  - write_disable_o=1.
  - On start_i: go to LOAD; pulse clear_debug_div_by_zero_o for 1 cycle; clear flip counter, flags and setup address.
- LOAD:
  - setup_o=1, load_ready_o=1, write_disable_o=0.
  - Each load_valid_i&load_ready_o: ucb_setup_wr_en_o=1, addr=internal address, data=load_data_i (combinational); address increments.
  - Transfer with load_last_i goes to SETTLE.
  - A transfer while the address equals BUFFER_DEPTH-1 without load_last_i goes to ERROR.
- SETTLE: one cycle, setup_o=0, lets the count register settle. Then buffer_count_i==0 goes to SAT, otherwise REQ.
- REQ:
  - Checks take priority in this order: ucb_overflow_i or debug_div_by_zero_i goes to ERROR; buffer_count_i==0 goes to SAT; max_flips_i!=0 and flip_count_o==max_flips_i goes to TIMEOUT.
  - Otherwise request_o=1 for exactly one cycle, then WAIT.
- WAIT:
  - Cycle counter runs SEL_LATENCY-1 cycles.
  - On the cycle where request_o was issued SEL_LATENCY cycles earlier, selected_i is captured into clause_o, then PRESENT.
- PRESENT: clause_valid_o=1, clause_o stable until clause_ready_i. Handshake cycle goes to FLIP and clause_valid_o drops next cycle.
- FLIP:
  - Waits for flip_done_i; flip_count_o increments on that cycle (saturates at all-ones), then REQ.
  - flip_done_i outside FLIP is ignored.
- Only one request is in flight at a time. A new request_o is never issued before the previous clause is consumed and its flip_done_i received.
- write_disable_o: 1 in IDLE, SAT, TIMEOUT, ERROR; 0 in all other states.
- SAT/TIMEOUT/ERROR:
  - Set the matching sticky flag and hold.
  - start_i restarts (as from IDLE, flags cleared).
- ucb_overflow_i or debug_div_by_zero_i in any non-IDLE, non-terminal state goes to ERROR next cycle. Overrides all other transitions, including a handshake in the same cycle.
- busy_o = state not in {IDLE, SAT, TIMEOUT, ERROR}.
- Reset mid-operation: immediate return to reset values; no partial write completes.

Decomposition:
- Shared package: state encoding enum, CLAUSE_WIDTH and BUF_ADDR_WIDTH derivations, SEL_LATENCY default.
- One natural sub-module, ucs_setup_loader: LOAD-phase address counter plus load handshake and overflow detect.

Test Plan:
- Load 3 clauses (A,B,C, last on C), buffer_count_i=3 -> 3 setup writes at addr 0,1,2; SETTLE then request_o exactly 1 cycle.
- Load then buffer_count_i=0 at SETTLE -> SAT, sat_o=1, request_o never asserted, write_disable_o=1.
- request_o at cycle T, selected_i=0x123456789 at T+4, clause_ready_i held low 5 cycles -> clause_valid_o high and clause_o stable 5 cycles; handshake then FLIP.
- max_flips_i=2, two flip_done_i pulses, count stays 5 -> flip_count_o=2, TIMEOUT, timeout_o=1, exactly 2 requests issued.
- debug_div_by_zero_i=1 during WAIT -> ERROR next cycle; start_i -> clear_debug_div_by_zero_o pulse, flags 0, LOAD.
- rst_i asserted mid-PRESENT -> clause_valid_o=0, write_disable_o=1, state IDLE asynchronously.

Source files
------------

// File: rtl/ucs_flip_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ucs_flip_scheduler_pkg
// Brief   : Shared types, defaults and width helpers for the flip scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package ucs_flip_scheduler_pkg;

    localparam int DEF_BUFFER_DEPTH          = 2048;
    localparam int DEF_NSAT                  = 3;
    localparam int DEF_LITERAL_ADDRESS_WIDTH = 12;
    localparam int DEF_FLIP_COUNT_WIDTH      = 32;
    localparam int DEF_SEL_LATENCY           = 4;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_REQ     = 4'd3,
        ST_WAIT    = 4'd4,
        ST_PRESENT = 4'd5,
        ST_FLIP    = 4'd6,
        ST_SAT     = 4'd7,
        ST_TIMEOUT = 4'd8,
        ST_ERROR   = 4'd9
    } state_t;

    function automatic int clause_width(input int nsat, input int lit_w);
        return nsat * lit_w;
    endfunction

    function automatic int buf_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // States in which the unsat buffer is frozen and start_i is accepted
    function automatic logic is_idle_or_terminal(input state_t s);
        return (s == ST_IDLE) || (s == ST_SAT) || (s == ST_TIMEOUT) || (s == ST_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucs_flip_scheduler_setup_loader.sv
`default_nettype none
// ============================================================================
// Module  : ucs_setup_loader
// Brief   : Host load handshake, setup write address counter, overflow detect.
// Revision: 1.0 - initial release
// ============================================================================
module ucs_setup_loader
    import ucs_flip_scheduler_pkg::*;
#(
    parameter int BUFFER_DEPTH   = DEF_BUFFER_DEPTH,
    parameter int CLAUSE_WIDTH   = clause_width(DEF_NSAT, DEF_LITERAL_ADDRESS_WIDTH),
    parameter int BUF_ADDR_WIDTH = buf_addr_width(BUFFER_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      active_i,
    input  logic                      load_valid_i,
    input  logic [CLAUSE_WIDTH-1:0]   load_data_i,
    input  logic                      load_last_i,
    output logic                      load_ready_o,
    output logic                      wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0] addr_o,
    output logic [CLAUSE_WIDTH-1:0]   data_o,
    output logic                      done_o,
    output logic                      overflow_o
);

    localparam logic [BUF_ADDR_WIDTH-1:0] c_last_addr = BUF_ADDR_WIDTH'(BUFFER_DEPTH - 1);

    logic [BUF_ADDR_WIDTH-1:0] r_addr;
    logic                      w_xfer;

    assign w_xfer       = active_i & load_valid_i;
    assign load_ready_o = active_i;
    assign wr_en_o      = w_xfer;
    assign addr_o       = r_addr;
    assign data_o       = w_xfer ? load_data_i : '0;
    assign done_o       = w_xfer & load_last_i;
    // Writing the final slot without closing the load leaves no room for the rest
    assign overflow_o   = w_xfer & ~load_last_i & (r_addr == c_last_addr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr <= '0;
        end else if (clear_i) begin
            r_addr <= '0;
        end else if (w_xfer) begin
            r_addr <= r_addr + BUF_ADDR_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ucs_flip_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ucs_flip_scheduler
// Brief   : Sequences buffer load, clause selection and flip handoff to SAT/limit.
// Revision: 1.0 - initial release
// ============================================================================
module ucs_flip_scheduler
    import ucs_flip_scheduler_pkg::*;
#(
    parameter int BUFFER_DEPTH           = DEF_BUFFER_DEPTH,
    parameter int NSAT                   = DEF_NSAT,
    parameter int LITERAL_ADDRESS_WIDTH  = DEF_LITERAL_ADDRESS_WIDTH,
    parameter int FLIP_COUNT_WIDTH       = DEF_FLIP_COUNT_WIDTH,
    parameter int SEL_LATENCY            = DEF_SEL_LATENCY,
    localparam int CLAUSE_WIDTH          = clause_width(NSAT, LITERAL_ADDRESS_WIDTH),
    localparam int BUF_ADDR_WIDTH        = buf_addr_width(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        load_valid_i,
    output logic                        load_ready_o,
    input  logic [CLAUSE_WIDTH-1:0]     load_data_i,
    input  logic                        load_last_i,
    output logic                        setup_o,
    output logic                        ucb_setup_wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0]   ucb_setup_addr_o,
    output logic [CLAUSE_WIDTH-1:0]     ucb_setup_data_o,
    output logic                        request_o,
    output logic                        write_disable_o,
    output logic                        clear_debug_div_by_zero_o,
    input  logic                        debug_div_by_zero_i,
    input  logic [BUF_ADDR_WIDTH-1:0]   buffer_count_i,
    input  logic                        ucb_overflow_i,
    input  logic [CLAUSE_WIDTH-1:0]     selected_i,
    output logic                        clause_valid_o,
    input  logic                        clause_ready_i,
    output logic [CLAUSE_WIDTH-1:0]     clause_o,
    input  logic                        flip_done_i,
    input  logic [FLIP_COUNT_WIDTH-1:0] max_flips_i,
    output logic [FLIP_COUNT_WIDTH-1:0] flip_count_o,
    output logic                        sat_o,
    output logic                        timeout_o,
    output logic                        error_o,
    output logic                        busy_o
);

    localparam int                c_wait_w    = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SEL_LATENCY - 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_wait_w-1:0]           r_wait_cnt;
    logic [CLAUSE_WIDTH-1:0]       r_clause;
    logic [FLIP_COUNT_WIDTH-1:0]   r_flip_count;
    logic                          r_sat;
    logic                          r_timeout;
    logic                          r_error;

    logic                          w_idle_or_term;
    logic                          w_start_accept;
    logic                          w_err_in;
    logic                          w_at_budget;
    logic                          w_request;
    logic                          w_capture;
    logic                          w_flip_inc;
    logic                          w_load_active;
    logic                          w_load_done;
    logic                          w_load_overflow;

    assign w_idle_or_term = is_idle_or_terminal(r_state);
    assign w_start_accept = start_i & w_idle_or_term;
    assign w_err_in       = ucb_overflow_i | debug_div_by_zero_i;
    assign w_at_budget    = (max_flips_i != '0) && (r_flip_count == max_flips_i);
    assign w_load_active  = (r_state == ST_LOAD);

    ucs_setup_loader #(
        .BUFFER_DEPTH   (BUFFER_DEPTH),
        .CLAUSE_WIDTH   (CLAUSE_WIDTH),
        .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_setup_loader (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (w_start_accept),
        .active_i     (w_load_active),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .wr_en_o      (ucb_setup_wr_en_o),
        .addr_o       (ucb_setup_addr_o),
        .data_o       (ucb_setup_data_o),
        .done_o       (w_load_done),
        .overflow_o   (w_load_overflow)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_request   = 1'b0;
        w_capture   = 1'b0;
        w_flip_inc  = 1'b0;
        case (r_state)
            ST_IDLE, ST_SAT, ST_TIMEOUT, ST_ERROR: begin
                if (start_i) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_load_overflow)  w_state_nxt = ST_ERROR;
                else if (w_load_done) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_state_nxt = (buffer_count_i == '0) ? ST_SAT : ST_REQ;
            end
            ST_REQ: begin
                if (w_err_in)                   w_state_nxt = ST_ERROR;
                else if (buffer_count_i == '0)  w_state_nxt = ST_SAT;
                else if (w_at_budget)           w_state_nxt = ST_TIMEOUT;
                else begin
                    w_request   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Last counted cycle lines up with the selector output
                if (r_wait_cnt == c_wait_last) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (clause_ready_i) w_state_nxt = ST_FLIP;
            end
            ST_FLIP: begin
                if (flip_done_i) begin
                    w_flip_inc  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Datapath faults win over every transition, including a same-cycle handshake
        if (!w_idle_or_term && w_err_in) begin
            w_state_nxt = ST_ERROR;
            w_request   = 1'b0;
            w_capture   = 1'b0;
            w_flip_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_clause     <= '0;
            r_flip_count <= '0;
            r_sat        <= 1'b0;
            r_timeout    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sat     <= (w_state_nxt == ST_SAT);
            r_timeout <= (w_state_nxt == ST_TIMEOUT);
            r_error   <= (w_state_nxt == ST_ERROR);

            if (w_start_accept) begin
                r_flip_count <= '0;
            end else if (w_flip_inc && (r_flip_count != '1)) begin
                r_flip_count <= r_flip_count + FLIP_COUNT_WIDTH'(1);
            end

            if (w_request) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
            end

            if (w_capture) r_clause <= selected_i;
        end
    end

    assign setup_o                   = w_load_active;
    assign request_o                 = w_request;
    assign write_disable_o           = w_idle_or_term;
    assign clear_debug_div_by_zero_o = w_start_accept;
    assign clause_valid_o            = (r_state == ST_PRESENT);
    assign clause_o                  = r_clause;
    assign flip_count_o              = r_flip_count;
    assign sat_o                     = r_sat;
    assign timeout_o                 = r_timeout;
    assign error_o                   = r_error;
    assign busy_o                    = ~w_idle_or_term;

endmodule
`default_nettype wire
